mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the 2:1/4:1 mux tree blocks.
- Two modes:
  - Manual: an external select picks the channel.
  - Auto-scan: an internal sequencer walks the channels round-robin, holding each one for a programmable dwell time.
- Output is registered and carries a valid flag plus a channel tag. Used to feed one shared W-bit datapath from several sources.

Parameters:
- WIDTH, 8, data width per channel in bits.
- CH, 4, number of input channels, range 2..16.
- DWELL_W, 4, width of the dwell-count input.
- SEL_W (localparam), $clog2(CH), width of the select and channel tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i  in  CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- s  in  SEL_W  manual select; used only when mode=0.
- mode  in  1  0 = manual, 1 = auto-scan.
- en  in  1  output update enable.
- dwell  in  DWELL_W  number of extra cycles each channel is held in scan mode.
- y  out  WIDTH  registered selected data.
- y_valid  out  1  y holds freshly sampled data this cycle.
- y_ch  out  SEL_W  channel index that y was taken from.

Behaviour:
- Reset:
  - rst is sampled on the clk edge only (synchronous, active-high).
  - While rst=1: y=0, y_valid=0, y_ch=0, scan index=0, dwell counter=0, FSM=MANUAL. This holds for rst asserted mid-scan; the next cycle after release starts clean.
- Latency: 1 cycle. y reflects the inputs sampled at the previous edge. No combinational path from inputs to outputs.
- FSM states: MANUAL, SCAN.
  - MANUAL -> SCAN when mode=1. On entry the scan index is 0 and the dwell counter is 0.
  - SCAN -> MANUAL when mode=0; takes effect the same edge.
  - A mode change during a dwell abandons that dwell. Re-entering SCAN always restarts at channel 0.
- en=0:
  - y and y_ch hold their values; y_valid=0.
  - The scan index and dwell counter freeze. The scan resumes exactly where it stopped.
- MANUAL, en=1:
  - If s<CH: y<=channel s, y_ch<=s, y_valid<=1.
  - If s>=CH (CH not a power of two): y<=0, y_ch<=s, y_valid<=0.
- SCAN, en=1:
  - Each cycle: y<=channel[idx], y_ch<=idx, y_valid<=1.
  - Dwell counter increments each cycle. When counter==dwell, the counter clears and idx advances.
  - idx wraps from CH-1 to 0.
  - Each channel is therefore presented for dwell+1 consecutive cycles. dwell=0 means a new channel every cycle.
- dwell changed mid-hold: the new value is compared from the next cycle. If counter>dwell, the counter clears and idx advances on that cycle (no wrap-around hang).
- No arithmetic overflow: the counter is DWELL_W bits and idx is SEL_W bits with explicit wrap at CH-1 (not modulo 2^SEL_W).

Optional Feature:
- Macro MUX_SCAN_MASK_EN.
- Defined:
  - Adds input port ch_mask [CH-1:0]. A 1 means the channel is enabled.
  - SCAN skips masked-off channels: the advance goes to the next enabled index with wrap. Skipping costs no extra cycles (search is combinational).
  - If the current idx becomes masked, it advances at the next edge regardless of the dwell count.
  - All-zero mask: y_valid=0, y holds, idx holds.
  - MANUAL selecting a masked channel: y<=0, y_valid=0.
- Undefined: port absent; all channels are always enabled; behaviour exactly as above.

Test Plan:
- Reset/manual: rst=1 for 2 cycles, then mode=0, en=1, i={8'h44,8'h33,8'h22,8'h11}, s=2 -> one cycle later y=8'h33, y_ch=2, y_valid=1. During reset y=0, y_valid=0.
- Scan, dwell=0: mode=1, en=1 -> y_ch sequence 0,1,2,3,0,1 on consecutive cycles, y_valid=1 throughout.
- Scan, dwell=2: y_ch = 0,0,0,1,1,1,2,2,2,3,3,3,0. Then en=0 for 3 cycles mid-channel-1 -> y holds, y_valid=0; after en=1 the remaining channel-1 cycles complete before channel 2.
- Mode/reset mid-scan: at y_ch=2, set mode=0 with s=1 -> next y_ch=1. Set mode=1 -> scan restarts at 0. Assert rst at y_ch=3 -> all outputs 0 next cycle.
- Non-power-of-2: CH=3, mode=0, s=3 -> y=0, y_valid=0. Scan wraps 0,1,2,0.
- MUX_SCAN_MASK_EN: ch_mask=4'b1010, dwell=0 -> y_ch 1,3,1,3. ch_mask=0 -> y_valid=0 and y held.

Source files
------------

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel, W-bit multiplexer with manual select
// and a round-robin auto-scan sequencer with a programmable dwell time.
// Optional feature: define MUX_SCAN_MASK_EN to add the ch_mask input, which
// lets the scan skip disabled channels and blocks manual access to them.
// Without the macro every channel is treated as enabled.
module mux_scan_n #(
   parameter  int WIDTH   = 8,
   parameter  int CH      = 4,
   parameter  int DWELL_W = 4,
   localparam int SEL_W   = $clog2(CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH*WIDTH-1:0]   i,
   input  logic [SEL_W-1:0]      s,
   input  logic                  mode,
   input  logic                  en,
   input  logic [DWELL_W-1:0]    dwell,
`ifdef MUX_SCAN_MASK_EN
   input  logic [CH-1:0]         ch_mask,
`endif
   output logic [WIDTH-1:0]      y,
   output logic                  y_valid,
   output logic [SEL_W-1:0]      y_ch
);

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     idx_q, idx_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic                 y_valid_q, y_valid_d;
   logic [SEL_W-1:0]     y_ch_q, y_ch_d;

   logic [CH-1:0]        mask;
   logic [SEL_W-1:0]     cur_idx;
   logic [DWELL_W-1:0]   cur_cnt;
   logic [SEL_W-1:0]     eff_idx;
   logic [DWELL_W-1:0]   eff_cnt;
   logic [WIDTH-1:0]     scan_data;
   logic [WIDTH-1:0]     man_data;
   logic                 man_ok;

   // Next enabled channel after 'from', wrapping at CH-1; returns 'from' if none
   function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] from,
                                                     input logic [CH-1:0]    m);
      logic [SEL_W-1:0] r;
      logic             found;
      int               c;
      r     = from;
      found = 1'b0;
      for (int k = 1; k <= CH; k++) begin
         c = (int'(from) + k) % CH;
         if (!found && m[c]) begin
            r     = SEL_W'(c);
            found = 1'b1;
         end
      end
      return r;
   endfunction

`ifdef MUX_SCAN_MASK_EN
   assign mask = ch_mask;
`else
   assign mask = '1;
`endif

   // Scan position as seen this cycle; a fresh entry into scan starts at channel 0
   always_comb begin
      cur_idx = '0;
      cur_cnt = '0;
      if (state_q == SCAN) begin
         cur_idx = idx_q;
         cur_cnt = cnt_q;
      end
      eff_idx = cur_idx;
      eff_cnt = cur_cnt;
      if (!mask[cur_idx]) begin
         eff_idx = next_enabled(cur_idx, mask);
         eff_cnt = '0;
      end
   end

   // Channel data picked by the scan index and by the manual select
   always_comb begin
      scan_data = '0;
      man_data  = '0;
      man_ok    = 1'b0;
      for (int k = 0; k < CH; k++) begin
         if (eff_idx == SEL_W'(k)) begin
            scan_data = i[k*WIDTH +: WIDTH];
         end
         if (s == SEL_W'(k)) begin
            man_data = i[k*WIDTH +: WIDTH];
            man_ok   = mask[k];
         end
      end
   end

   // Mode FSM, scan sequencing with dwell, and next output values
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      y_ch_d    = y_ch_q;
      if (mode) begin
         state_d = SCAN;
         idx_d   = cur_idx;
         cnt_d   = cur_cnt;
         if (en && (mask != '0)) begin
            y_d       = scan_data;
            y_ch_d    = eff_idx;
            y_valid_d = 1'b1;
            if (eff_cnt >= dwell) begin
               cnt_d = '0;
               idx_d = next_enabled(eff_idx, mask);
            end else begin
               idx_d = eff_idx;
               cnt_d = eff_cnt + DWELL_W'(1);
            end
         end
      end else begin
         state_d = MANUAL;
         idx_d   = '0;
         cnt_d   = '0;
         if (en) begin
            y_ch_d = s;
            if (man_ok) begin
               y_d       = man_data;
               y_valid_d = 1'b1;
            end else begin
               y_d = '0;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MANUAL;
         idx_q     <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         y_ch_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         y_ch_q    <= y_ch_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign y_ch    = y_ch_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed self-checking bench for mux_scan_n.
// Drives a 4-channel and a 3-channel instance; the masking scenario is
// compiled in only when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_n;

   logic        clk;
   logic        rst;
   logic [31:0] i;
   logic [1:0]  s;
   logic        mode;
   logic        en;
   logic [3:0]  dwell;
   logic [7:0]  y;
   logic        y_valid;
   logic [1:0]  y_ch;

   logic [23:0] i3;
   logic [1:0]  s3;
   logic        mode3;
   logic        en3;
   logic [3:0]  dwell3;
   logic [7:0]  y3;
   logic        y_valid3;
   logic [1:0]  y_ch3;

`ifdef MUX_SCAN_MASK_EN
   logic [3:0]  ch_mask;
   logic [2:0]  ch_mask3;
`endif

   int errors = 0;
   int checks = 0;

   mux_scan_n #(.WIDTH(8), .CH(4), .DWELL_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .i       (i),
      .s       (s),
      .mode    (mode),
      .en      (en),
      .dwell   (dwell),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask (ch_mask),
`endif
      .y       (y),
      .y_valid (y_valid),
      .y_ch    (y_ch)
   );

   mux_scan_n #(.WIDTH(8), .CH(3), .DWELL_W(4)) dut3 (
      .clk     (clk),
      .rst     (rst),
      .i       (i3),
      .s       (s3),
      .mode    (mode3),
      .en      (en3),
      .dwell   (dwell3),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask (ch_mask3),
`endif
      .y       (y3),
      .y_valid (y_valid3),
      .y_ch    (y_ch3)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic m, input logic e,
                                input logic [1:0] sel, input logic [3:0] dw);
      mode  = m;
      en    = e;
      s     = sel;
      dwell = dw;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         applyStimulus(1'b0, 1'b1, 2'd2, 4'd0);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b0, 2'd0, 8'h00}) begin
            $display("[TB] FAIL reset_hold cycle %0d: got v=%0b ch=%0d y=%h, expected v=0 ch=0 y=00",
                     n, y_valid, y_ch, y);
            errors++;
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      logic [1:0] sel_list [3] = '{2'd2, 2'd0, 2'd3};
      logic [7:0] exp_y    [3] = '{8'h33, 8'h11, 8'h44};
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b0, 1'b1, sel_list[n], 4'd0);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, sel_list[n], exp_y[n]}) begin
            $display("[TB] FAIL manual s=%0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     sel_list[n], y_valid, y_ch, y, sel_list[n], exp_y[n]);
            errors++;
         end
      end
   endtask

   task automatic test_scan_dwell0();
      int         exp_ch [6] = '{0, 1, 2, 3, 0, 1};
      logic [1:0] e_ch;
      logic [7:0] e_y;
      for (int n = 0; n < 6; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
         e_ch = 2'(exp_ch[n]);
         e_y  = 8'((exp_ch[n] + 1) * 17);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, e_ch, e_y}) begin
            $display("[TB] FAIL scan_dwell0 step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid, y_ch, y, e_ch, e_y);
            errors++;
         end
      end
   endtask

   task automatic test_scan_dwell2_and_enable();
      int         exp_ch [16] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1};
      int         res_ch [3]  = '{1, 1, 2};
      logic [1:0] e_ch;
      logic [7:0] e_y;
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd2);
      checks++;
      if ({y_valid, y_ch, y} !== {1'b1, 2'd0, 8'h11}) begin
         $display("[TB] FAIL dwell2_manual_gap: got v=%0b ch=%0d y=%h, expected v=1 ch=0 y=11",
                  y_valid, y_ch, y);
         errors++;
      end
      for (int n = 0; n < 16; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd2);
         e_ch = 2'(exp_ch[n]);
         e_y  = 8'((exp_ch[n] + 1) * 17);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, e_ch, e_y}) begin
            $display("[TB] FAIL scan_dwell2 step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid, y_ch, y, e_ch, e_y);
            errors++;
         end
      end
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b0, 2'd0, 4'd2);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b0, 2'd1, 8'h22}) begin
            $display("[TB] FAIL en_low_hold %0d: got v=%0b ch=%0d y=%h, expected v=0 ch=1 y=22",
                     n, y_valid, y_ch, y);
            errors++;
         end
      end
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd2);
         e_ch = 2'(res_ch[n]);
         e_y  = 8'((res_ch[n] + 1) * 17);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, e_ch, e_y}) begin
            $display("[TB] FAIL en_resume step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid, y_ch, y, e_ch, e_y);
            errors++;
         end
      end
   endtask

   task automatic test_mode_and_reset_mid_scan();
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
      end
      checks++;
      if (y_ch !== 2'd2) begin
         $display("[TB] FAIL mid_scan_pos: got ch=%0d, expected ch=2", y_ch);
         errors++;
      end
      applyStimulus(1'b0, 1'b1, 2'd1, 4'd0);
      checks++;
      if ({y_valid, y_ch, y} !== {1'b1, 2'd1, 8'h22}) begin
         $display("[TB] FAIL mode_to_manual: got v=%0b ch=%0d y=%h, expected v=1 ch=1 y=22",
                  y_valid, y_ch, y);
         errors++;
      end
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd0);
      checks++;
      if ({y_valid, y_ch, y} !== {1'b1, 2'd0, 8'h11}) begin
         $display("[TB] FAIL scan_restart: got v=%0b ch=%0d y=%h, expected v=1 ch=0 y=11",
                  y_valid, y_ch, y);
         errors++;
      end
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd1, 4'd0);
      end
      checks++;
      if ({y_valid, y_ch, y} !== {1'b1, 2'd3, 8'h44}) begin
         $display("[TB] FAIL pre_reset_pos: got v=%0b ch=%0d y=%h, expected v=1 ch=3 y=44",
                  y_valid, y_ch, y);
         errors++;
      end
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd0);
      rst = 1'b0;
      checks++;
      if ({y_valid, y_ch, y} !== {1'b0, 2'd0, 8'h00}) begin
         $display("[TB] FAIL reset_mid_scan: got v=%0b ch=%0d y=%h, expected v=0 ch=0 y=00",
                  y_valid, y_ch, y);
         errors++;
      end
      applyStimulus(1'b1, 1'b1, 2'd1, 4'd0);
      checks++;
      if ({y_valid, y_ch, y} !== {1'b1, 2'd0, 8'h11}) begin
         $display("[TB] FAIL post_reset_scan: got v=%0b ch=%0d y=%h, expected v=1 ch=0 y=11",
                  y_valid, y_ch, y);
         errors++;
      end
   endtask

   task automatic test_dwell_change();
      int         exp_ch [4] = '{0, 1, 1, 2};
      logic [1:0] e_ch;
      logic [7:0] e_y;
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd3);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd3);
      end
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd1);
         e_ch = 2'(exp_ch[n]);
         e_y  = 8'((exp_ch[n] + 1) * 17);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, e_ch, e_y}) begin
            $display("[TB] FAIL dwell_shrink step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid, y_ch, y, e_ch, e_y);
            errors++;
         end
      end
   endtask

   task automatic test_non_pow2();
      logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
      logic [7:0] exp_y  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hAA};
      mode3 = 1'b0; en3 = 1'b1; s3 = 2'd2; dwell3 = 4'd0;
      tick();
      checks++;
      if ({y_valid3, y_ch3, y3} !== {1'b1, 2'd2, 8'hCC}) begin
         $display("[TB] FAIL ch3_manual_s2: got v=%0b ch=%0d y=%h, expected v=1 ch=2 y=cc",
                  y_valid3, y_ch3, y3);
         errors++;
      end
      s3 = 2'd3;
      tick();
      checks++;
      if ({y_valid3, y_ch3, y3} !== {1'b0, 2'd3, 8'h00}) begin
         $display("[TB] FAIL ch3_manual_oob: got v=%0b ch=%0d y=%h, expected v=0 ch=3 y=00",
                  y_valid3, y_ch3, y3);
         errors++;
      end
      mode3 = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++;
         if ({y_valid3, y_ch3, y3} !== {1'b1, exp_ch[n], exp_y[n]}) begin
            $display("[TB] FAIL ch3_scan step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid3, y_ch3, y3, exp_ch[n], exp_y[n]);
            errors++;
         end
      end
      mode3 = 1'b0;
   endtask

`ifdef MUX_SCAN_MASK_EN
   task automatic test_mask();
      int         exp_ch [4] = '{1, 3, 1, 3};
      logic [1:0] e_ch;
      logic [7:0] e_y;
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
      ch_mask = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
         e_ch = 2'(exp_ch[n]);
         e_y  = 8'((exp_ch[n] + 1) * 17);
         checks++;
         if ({y_valid, y_ch, y} !== {1'b1, e_ch, e_y}) begin
            $display("[TB] FAIL mask_scan step %0d: got v=%0b ch=%0d y=%h, expected v=1 ch=%0d y=%h",
                     n, y_valid, y_ch, y, e_ch, e_y);
            errors++;
         end
      end
      ch_mask = 4'b0000;
      applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
      checks++;
      if ({y_valid, y_ch, y} !== {1'b0, 2'd3, 8'h44}) begin
         $display("[TB] FAIL mask_all_off: got v=%0b ch=%0d y=%h, expected v=0 ch=3 y=44",
                  y_valid, y_ch, y);
         errors++;
      end
      ch_mask = 4'b1010;
      applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
      checks++;
      if ({y_valid, y} !== {1'b0, 8'h00}) begin
         $display("[TB] FAIL mask_manual_off: got v=%0b y=%h, expected v=0 y=00", y_valid, y);
         errors++;
      end
      ch_mask = 4'b1111;
   endtask
`endif

   // Scenario sequence
   initial begin
      rst   = 1'b1;
      i     = {8'h44, 8'h33, 8'h22, 8'h11};
      s     = 2'd0;
      mode  = 1'b0;
      en    = 1'b0;
      dwell = 4'd0;
      i3    = {8'hCC, 8'hBB, 8'hAA};
      s3    = 2'd0;
      mode3 = 1'b0;
      en3   = 1'b0;
      dwell3 = 4'd0;
`ifdef MUX_SCAN_MASK_EN
      ch_mask  = 4'b1111;
      ch_mask3 = 3'b111;
`endif
      #2;
      test_reset();
      test_manual();
      test_scan_dwell0();
      test_scan_dwell2_and_enable();
      test_mode_and_reset_mid_scan();
      test_dwell_change();
      test_non_pow2();
`ifdef MUX_SCAN_MASK_EN
      test_mask();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
